// File: rtl/axi_lite_rr_arbiter.sv
// rtl/axi_lite_rr_arbiter.sv - N-master to 1-slave AXI-lite round-robin arbiter with per-transaction lock
//
// Purpose:
//   Grants the shared slave to one master at a time and holds the grant until
//   the R (read) or B (write) response has been accepted. Only one transaction
//   is outstanding in the whole block. Round-robin scan starts just after the
//   last completed grant, so continuously requesting masters are served in turn.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   m_*                  flattened per-master AXI-lite channels, master i at [i*W +: W]
//   s_*                  single AXI-lite master port toward the shared slave
//   grant_idx            currently granted master (0 while idle)
//   busy                 high whenever a transaction is being served

module axi_lite_rr_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [NUM_M*ADDR_W-1:0]       m_araddr,
    input  logic [NUM_M-1:0]              m_arvalid,
    output logic [NUM_M-1:0]              m_arready,
    output logic [NUM_M*DATA_W-1:0]       m_rdata,
    output logic [NUM_M*2-1:0]            m_rresp,
    output logic [NUM_M-1:0]              m_rvalid,
    input  logic [NUM_M-1:0]              m_rready,
    input  logic [NUM_M*ADDR_W-1:0]       m_awaddr,
    input  logic [NUM_M-1:0]              m_awvalid,
    output logic [NUM_M-1:0]              m_awready,
    input  logic [NUM_M*DATA_W-1:0]       m_wdata,
    input  logic [NUM_M*(DATA_W/8)-1:0]   m_wstrb,
    input  logic [NUM_M-1:0]              m_wvalid,
    output logic [NUM_M-1:0]              m_wready,
    output logic [NUM_M*2-1:0]            m_bresp,
    output logic [NUM_M-1:0]              m_bvalid,
    input  logic [NUM_M-1:0]              m_bready,

    output logic [ADDR_W-1:0]             s_araddr,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic [1:0]                    s_rresp,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    output logic [ADDR_W-1:0]             s_awaddr,
    output logic                          s_awvalid,
    input  logic                          s_awready,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    output logic                          s_wvalid,
    input  logic                          s_wready,
    input  logic [1:0]                    s_bresp,
    input  logic                          s_bvalid,
    output logic                          s_bready,

    output logic [$clog2(NUM_M)-1:0]      grant_idx,
    output logic                          busy
);

    localparam int IDX_W  = $clog2(NUM_M);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [IDX_W:0] NUM_M_W = (IDX_W+1)'(NUM_M);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_D,
        ST_WR_AW,
        ST_WR_B
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_ptr;
    logic               r_aw_done;
    logic               r_w_done;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               w_aw_done_nxt;
    logic               w_w_done_nxt;

    logic [NUM_M-1:0]   w_req;
    logic               w_any;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W:0]     w_cand;

    logic               w_aw_hs;
    logic               w_w_hs;

    // Channel signals of the granted master, extracted once so the FSM
    // below can treat the selected master like a single port.
    logic [ADDR_W-1:0]  w_g_araddr;
    logic               w_g_arvalid;
    logic               w_g_rready;
    logic [ADDR_W-1:0]  w_g_awaddr;
    logic               w_g_awvalid;
    logic [DATA_W-1:0]  w_g_wdata;
    logic [STRB_W-1:0]  w_g_wstrb;
    logic               w_g_wvalid;
    logic               w_g_bready;

    assign w_req     = m_arvalid | m_awvalid;
    assign busy      = (r_state != ST_IDLE);
    assign grant_idx = busy ? r_grant : '0;

    always_comb begin
        w_g_araddr  = '0;
        w_g_arvalid = 1'b0;
        w_g_rready  = 1'b0;
        w_g_awaddr  = '0;
        w_g_awvalid = 1'b0;
        w_g_wdata   = '0;
        w_g_wstrb   = '0;
        w_g_wvalid  = 1'b0;
        w_g_bready  = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (IDX_W'(i) == r_grant) begin
                w_g_araddr  = m_araddr[i*ADDR_W +: ADDR_W];
                w_g_arvalid = m_arvalid[i];
                w_g_rready  = m_rready[i];
                w_g_awaddr  = m_awaddr[i*ADDR_W +: ADDR_W];
                w_g_awvalid = m_awvalid[i];
                w_g_wdata   = m_wdata[i*DATA_W +: DATA_W];
                w_g_wstrb   = m_wstrb[i*STRB_W +: STRB_W];
                w_g_wvalid  = m_wvalid[i];
                w_g_bready  = m_bready[i];
            end
        end
    end

    // Round-robin search: candidates ptr+1, ptr+2, ... wrapping modulo NUM_M.
    // The sum is one bit wider than an index so the wrap works for any NUM_M.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_cand >= NUM_M_W) begin
                w_cand = w_cand - NUM_M_W;
            end
            if (!w_any && w_req[w_cand[IDX_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_ptr_nxt     = r_ptr;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_aw_hs       = 1'b0;
        w_w_hs        = 1'b0;

        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;

        m_arready = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rvalid  = '0;
        m_awready = '0;
        m_wready  = '0;
        m_bresp   = '0;
        m_bvalid  = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_win;
                    // A master offering both a read and a write is served write first.
                    w_state_nxt = m_awvalid[w_win] ? ST_WR_AW : ST_RD_A;
                end
            end
            ST_RD_A: begin
                s_araddr  = w_g_araddr;
                s_arvalid = w_g_arvalid;
                if (w_g_arvalid && s_arready) begin
                    w_state_nxt = ST_RD_D;
                end
            end
            ST_RD_D: begin
                s_rready = w_g_rready;
                if (s_rvalid && w_g_rready) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = r_grant;
                end
            end
            ST_WR_AW: begin
                // AW and W complete independently; each valid is withdrawn
                // once its own handshake has been recorded.
                s_awaddr  = w_g_awaddr;
                s_awvalid = w_g_awvalid && !r_aw_done;
                s_wdata   = w_g_wdata;
                s_wstrb   = w_g_wstrb;
                s_wvalid  = w_g_wvalid && !r_w_done;
                w_aw_hs   = s_awvalid && s_awready;
                w_w_hs    = s_wvalid && s_wready;
                if (w_aw_hs) begin
                    w_aw_done_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_w_done_nxt = 1'b1;
                end
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_nxt = ST_WR_B;
                end
            end
            ST_WR_B: begin
                s_bready = w_g_bready;
                if (s_bvalid && w_g_bready) begin
                    w_state_nxt   = ST_IDLE;
                    w_ptr_nxt     = r_grant;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        for (int i = 0; i < NUM_M; i++) begin
            if (IDX_W'(i) == r_grant) begin
                m_arready[i] = (r_state == ST_RD_A) && s_arready;
                if (r_state == ST_RD_D) begin
                    m_rvalid[i]               = s_rvalid;
                    m_rdata[i*DATA_W +: DATA_W] = s_rdata;
                    m_rresp[i*2 +: 2]         = s_rresp;
                end
                if (r_state == ST_WR_AW) begin
                    m_awready[i] = s_awready && !r_aw_done;
                    m_wready[i]  = s_wready && !r_w_done;
                end
                if (r_state == ST_WR_B) begin
                    m_bvalid[i]       = s_bvalid;
                    m_bresp[i*2 +: 2] = s_bresp;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_ptr     <= IDX_W'(NUM_M - 1);
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_ptr     <= w_ptr_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// tb/tb_axi_lite_rr_arbiter.sv - self-checking bench for axi_lite_rr_arbiter (NUM_M=2 and NUM_M=4)

module tb_axi_lite_rr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    // two-master instance
    logic [2*AW-1:0] a_m_araddr;  logic [1:0] a_m_arvalid, a_m_arready;
    logic [2*DW-1:0] a_m_rdata;   logic [3:0] a_m_rresp;
    logic [1:0]      a_m_rvalid,  a_m_rready;
    logic [2*AW-1:0] a_m_awaddr;  logic [1:0] a_m_awvalid, a_m_awready;
    logic [2*DW-1:0] a_m_wdata;   logic [7:0] a_m_wstrb;
    logic [1:0]      a_m_wvalid,  a_m_wready;
    logic [3:0]      a_m_bresp;   logic [1:0] a_m_bvalid, a_m_bready;
    logic [AW-1:0]   a_s_araddr;  logic a_s_arvalid, a_s_arready;
    logic [DW-1:0]   a_s_rdata;   logic [1:0] a_s_rresp; logic a_s_rvalid, a_s_rready;
    logic [AW-1:0]   a_s_awaddr;  logic a_s_awvalid, a_s_awready;
    logic [DW-1:0]   a_s_wdata;   logic [3:0] a_s_wstrb; logic a_s_wvalid, a_s_wready;
    logic [1:0]      a_s_bresp;   logic a_s_bvalid, a_s_bready;
    logic [0:0]      a_grant;     logic a_busy;

    // four-master instance
    logic [4*AW-1:0] b_m_araddr;  logic [3:0] b_m_arvalid, b_m_arready;
    logic [4*DW-1:0] b_m_rdata;   logic [7:0] b_m_rresp;
    logic [3:0]      b_m_rvalid,  b_m_rready;
    logic [4*AW-1:0] b_m_awaddr;  logic [3:0] b_m_awvalid, b_m_awready;
    logic [4*DW-1:0] b_m_wdata;   logic [15:0] b_m_wstrb;
    logic [3:0]      b_m_wvalid,  b_m_wready;
    logic [7:0]      b_m_bresp;   logic [3:0] b_m_bvalid, b_m_bready;
    logic [AW-1:0]   b_s_araddr;  logic b_s_arvalid, b_s_arready;
    logic [DW-1:0]   b_s_rdata;   logic [1:0] b_s_rresp; logic b_s_rvalid, b_s_rready;
    logic [AW-1:0]   b_s_awaddr;  logic b_s_awvalid, b_s_awready;
    logic [DW-1:0]   b_s_wdata;   logic [3:0] b_s_wstrb; logic b_s_wvalid, b_s_wready;
    logic [1:0]      b_s_bresp;   logic b_s_bvalid, b_s_bready;
    logic [1:0]      b_grant;     logic b_busy;

    axi_lite_rr_arbiter #(.NUM_M(2), .ADDR_W(AW), .DATA_W(DW)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .m_araddr(a_m_araddr), .m_arvalid(a_m_arvalid), .m_arready(a_m_arready),
        .m_rdata(a_m_rdata), .m_rresp(a_m_rresp), .m_rvalid(a_m_rvalid), .m_rready(a_m_rready),
        .m_awaddr(a_m_awaddr), .m_awvalid(a_m_awvalid), .m_awready(a_m_awready),
        .m_wdata(a_m_wdata), .m_wstrb(a_m_wstrb), .m_wvalid(a_m_wvalid), .m_wready(a_m_wready),
        .m_bresp(a_m_bresp), .m_bvalid(a_m_bvalid), .m_bready(a_m_bready),
        .s_araddr(a_s_araddr), .s_arvalid(a_s_arvalid), .s_arready(a_s_arready),
        .s_rdata(a_s_rdata), .s_rresp(a_s_rresp), .s_rvalid(a_s_rvalid), .s_rready(a_s_rready),
        .s_awaddr(a_s_awaddr), .s_awvalid(a_s_awvalid), .s_awready(a_s_awready),
        .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb), .s_wvalid(a_s_wvalid), .s_wready(a_s_wready),
        .s_bresp(a_s_bresp), .s_bvalid(a_s_bvalid), .s_bready(a_s_bready),
        .grant_idx(a_grant), .busy(a_busy)
    );

    axi_lite_rr_arbiter #(.NUM_M(4), .ADDR_W(AW), .DATA_W(DW)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .m_araddr(b_m_araddr), .m_arvalid(b_m_arvalid), .m_arready(b_m_arready),
        .m_rdata(b_m_rdata), .m_rresp(b_m_rresp), .m_rvalid(b_m_rvalid), .m_rready(b_m_rready),
        .m_awaddr(b_m_awaddr), .m_awvalid(b_m_awvalid), .m_awready(b_m_awready),
        .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb), .m_wvalid(b_m_wvalid), .m_wready(b_m_wready),
        .m_bresp(b_m_bresp), .m_bvalid(b_m_bvalid), .m_bready(b_m_bready),
        .s_araddr(b_s_araddr), .s_arvalid(b_s_arvalid), .s_arready(b_s_arready),
        .s_rdata(b_s_rdata), .s_rresp(b_s_rresp), .s_rvalid(b_s_rvalid), .s_rready(b_s_rready),
        .s_awaddr(b_s_awaddr), .s_awvalid(b_s_awvalid), .s_awready(b_s_awready),
        .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_wvalid(b_s_wvalid), .s_wready(b_s_wready),
        .s_bresp(b_s_bresp), .s_bvalid(b_s_bvalid), .s_bready(b_s_bready),
        .grant_idx(b_grant), .busy(b_busy)
    );

    typedef struct {
        logic [3:0] rd;
        logic [3:0] wr;
        logic [1:0] g;
        logic       w;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [1:0] gr [4];
        int         ng;
        int         viol;
        int         n;
        logic       pb;

        rst_n = 1'b0;
        a_m_araddr = '0; a_m_arvalid = '0; a_m_rready = '0;
        a_m_awaddr = '0; a_m_awvalid = '0; a_m_wdata = '0; a_m_wstrb = '0;
        a_m_wvalid = '0; a_m_bready = '0;
        a_s_arready = 1'b0; a_s_rdata = '0; a_s_rresp = '0; a_s_rvalid = 1'b0;
        a_s_awready = 1'b0; a_s_wready = 1'b0; a_s_bresp = '0; a_s_bvalid = 1'b0;
        b_m_araddr = '0; b_m_arvalid = '0; b_m_rready = 4'hF;
        b_m_awaddr = '0; b_m_awvalid = '0; b_m_wdata = '0; b_m_wstrb = '0;
        b_m_wvalid = '0; b_m_bready = 4'hF;
        b_s_arready = 1'b1; b_s_rdata = 32'h0BAD_F00D; b_s_rresp = '0; b_s_rvalid = 1'b1;
        b_s_awready = 1'b1; b_s_wready = 1'b1; b_s_bresp = '0; b_s_bvalid = 1'b1;

        tbl[0] = '{rd: 4'b0100, wr: 4'b0000, g: 2'd2, w: 1'b0};
        tbl[1] = '{rd: 4'b1111, wr: 4'b0000, g: 2'd3, w: 1'b0};
        tbl[2] = '{rd: 4'b1111, wr: 4'b0000, g: 2'd0, w: 1'b0};
        tbl[3] = '{rd: 4'b1111, wr: 4'b0000, g: 2'd1, w: 1'b0};
        tbl[4] = '{rd: 4'b1111, wr: 4'b0000, g: 2'd2, w: 1'b0};
        tbl[5] = '{rd: 4'b0000, wr: 4'b0010, g: 2'd1, w: 1'b1};
        tbl[6] = '{rd: 4'b0001, wr: 4'b1000, g: 2'd3, w: 1'b1};
        tbl[7] = '{rd: 4'b1001, wr: 4'b0001, g: 2'd0, w: 1'b1};
        tbl[8] = '{rd: 4'b0001, wr: 4'b0000, g: 2'd0, w: 1'b0};
        tbl[9] = '{rd: 4'b0110, wr: 4'b0000, g: 2'd1, w: 1'b0};

        repeat (3) @(negedge clk);
        check("rst_busy", a_busy, 0);
        check("rst_grant", a_grant, 0);
        check("rst_s_arvalid", a_s_arvalid, 0);
        check("rst_m_arready", a_m_arready, 0);
        check("rst_b_busy", b_busy, 0);
        rst_n = 1'b1;

        // single read by m0 with a 3-cycle slave latency
        @(negedge clk);
        a_m_araddr[31:0] = 32'h8000_0010; a_m_arvalid = 2'b01; a_m_rready = 2'b01;
        a_s_arready = 1'b1;
        #1 check("t1_no_early_arvalid", a_s_arvalid, 0);
        @(negedge clk);
        check("t1_s_arvalid", a_s_arvalid, 1);
        check("t1_s_araddr", a_s_araddr, 32'h8000_0010);
        check("t1_grant", a_grant, 0);
        check("t1_m_arready", a_m_arready, 2'b01);
        @(negedge clk);
        a_m_arvalid = 2'b00; a_s_arready = 1'b0;
        check("t1_araddr_zero_rd_d", a_s_araddr, 0);
        check("t1_rvalid_wait", a_m_rvalid, 0);
        @(negedge clk);
        @(negedge clk);
        a_s_rvalid = 1'b1; a_s_rdata = 32'hDEAD_BEEF; a_s_rresp = 2'b00;
        #1;
        check("t1_m_rvalid", a_m_rvalid, 2'b01);
        check("t1_m_rdata", a_m_rdata, {32'h0, 32'hDEAD_BEEF});
        check("t1_m_rresp", a_m_rresp, 0);
        check("t1_busy_in_rd_d", a_busy, 1);
        @(negedge clk);
        check("t1_busy_fall", a_busy, 0);
        a_s_rvalid = 1'b0; a_s_rdata = '0;

        // reset while m1 sits in RD_D with slave rvalid high
        a_m_arvalid = 2'b10; a_m_rready = 2'b00; a_s_arready = 1'b1;
        a_s_rvalid = 1'b1; a_s_rdata = 32'hCAFE_0001;
        @(negedge clk);
        check("t6_grant1", a_grant, 1);
        @(negedge clk);
        check("t6_m_rvalid", a_m_rvalid, 2'b10);
        check("t6_m_rdata", a_m_rdata, {32'hCAFE_0001, 32'h0});
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_busy", a_busy, 0);
        check("t6_m_rvalid_rst", a_m_rvalid, 0);
        check("t6_grant_rst", a_grant, 0);
        check("t6_s_rready_rst", a_s_rready, 0);
        rst_n = 1'b1;

        // both masters read continuously: alternation starting from master 0
        a_m_arvalid = 2'b11; a_m_rready = 2'b11;
        ng = 0; viol = 0; pb = 1'b0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (a_busy && a_grant == 1'b0 && a_m_rvalid[1]) viol++;
            if (a_busy && !pb) begin
                gr[ng] = {1'b0, a_grant};
                ng++;
            end
            pb = a_busy;
        end
        check("t2_num_grants", ng, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) check($sformatf("t2_grant%0d", k), gr[k], k % 2);
        end
        @(negedge clk);
        if (a_grant == 1'b0 && a_m_rvalid[1]) viol++;
        check("t2_m1_rvalid_during_m0", viol, 0);
        a_m_arvalid = 2'b00;
        @(negedge clk);
        check("t2_idle", a_busy, 0);
        a_s_rvalid = 1'b0; a_s_arready = 1'b0;

        // m1 write, W offered two cycles before AW
        a_m_wvalid = 2'b10; a_m_wdata[63:32] = 32'h1234_5678; a_m_wstrb[7:4] = 4'b0011;
        a_s_wready = 1'b1; a_s_awready = 1'b0; a_m_bready = 2'b10;
        @(negedge clk);
        check("t3_w_alone_no_req", a_busy, 0);
        check("t3_m_wready_idle", a_m_wready, 0);
        @(negedge clk);
        a_m_awaddr[63:32] = 32'h0000_0040; a_m_awvalid = 2'b10;
        @(negedge clk);
        check("t3_grant", a_grant, 1);
        check("t3_s_wvalid", a_s_wvalid, 1);
        check("t3_s_wdata", a_s_wdata, 32'h1234_5678);
        check("t3_s_wstrb", a_s_wstrb, 4'b0011);
        check("t3_s_awvalid", a_s_awvalid, 1);
        check("t3_s_awaddr", a_s_awaddr, 32'h40);
        check("t3_m_wready", a_m_wready, 2'b10);
        check("t3_m_awready_low", a_m_awready, 0);
        @(negedge clk);
        check("t3_s_wvalid_dropped", a_s_wvalid, 0);
        check("t3_m_wready_dropped", a_m_wready, 0);
        check("t3_s_awvalid_held", a_s_awvalid, 1);
        a_s_awready = 1'b1;
        #1 check("t3_m_awready", a_m_awready, 2'b10);
        @(negedge clk);
        check("t3_s_awvalid_wr_b", a_s_awvalid, 0);
        check("t3_s_bready", a_s_bready, 1);
        a_m_awvalid = 2'b00; a_m_wvalid = 2'b00;
        a_s_bvalid = 1'b1; a_s_bresp = 2'b10;
        #1;
        check("t3_m_bvalid", a_m_bvalid, 2'b10);
        check("t3_m_bresp", a_m_bresp, 4'b1000);
        check("t3_no_rvalid", a_m_rvalid, 0);
        @(negedge clk);
        check("t3_idle", a_busy, 0);
        a_s_bvalid = 1'b0; a_s_bresp = 2'b00;

        // m0 offers write and read together: write first, read on a later grant
        a_m_awaddr[31:0] = 32'h100; a_m_awvalid = 2'b01; a_m_wvalid = 2'b01;
        a_m_wdata[31:0] = 32'hA5A5_5A5A; a_m_wstrb[3:0] = 4'hF;
        a_m_araddr[31:0] = 32'h200; a_m_arvalid = 2'b01;
        a_m_bready = 2'b01; a_m_rready = 2'b01;
        a_s_awready = 1'b1; a_s_wready = 1'b1; a_s_bvalid = 1'b1;
        a_s_arready = 1'b1; a_s_rvalid = 1'b1;
        @(negedge clk);
        check("t4_busy", a_busy, 1);
        check("t4_grant", a_grant, 0);
        check("t4_write_first", a_s_awvalid, 1);
        check("t4_no_read_yet", a_s_arvalid, 0);
        @(negedge clk);
        check("t4_m_bvalid", a_m_bvalid, 2'b01);
        a_m_awvalid = 2'b00; a_m_wvalid = 2'b00;
        @(negedge clk);
        check("t4_idle_between", a_busy, 0);
        @(negedge clk);
        check("t4_read_busy", a_busy, 1);
        check("t4_read_arvalid", a_s_arvalid, 1);
        check("t4_read_araddr", a_s_araddr, 32'h200);
        check("t4_read_no_aw", a_s_awvalid, 0);
        @(negedge clk);
        check("t4_m_rvalid", a_m_rvalid, 2'b01);
        a_m_arvalid = 2'b00;
        @(negedge clk);
        check("t4_done", a_busy, 0);
        a_s_awready = 1'b0; a_s_wready = 1'b0; a_s_bvalid = 1'b0;
        a_s_arready = 1'b0; a_s_rvalid = 1'b0;

        // four-master arbitration table, slave always ready/responding
        for (int i = 0; i < 10; i++) begin
            b_m_arvalid = tbl[i].rd;
            b_m_awvalid = tbl[i].wr;
            b_m_wvalid  = tbl[i].wr;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!b_busy && n < 10);
            check($sformatf("v%0d_busy", i), b_busy, 1);
            check($sformatf("v%0d_grant", i), b_grant, tbl[i].g);
            check($sformatf("v%0d_awvalid", i), b_s_awvalid, tbl[i].w);
            check($sformatf("v%0d_arvalid", i), b_s_arvalid, !tbl[i].w);
            n = 0;
            while (b_busy && n < 10) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("v%0d_complete", i), b_busy, 0);
        end
        b_m_arvalid = '0; b_m_awvalid = '0; b_m_wvalid = '0;
        @(negedge clk);
        @(negedge clk);
        check("v_final_idle", b_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
